// File: rtl/countdown_timer.sv
// -----------------------------------------------------------------------------
// countdown_timer
//
// Loadable down-counter with start / pause / stop control and an optional
// auto-reload. When the count expires while running, done_o pulses for one
// cycle. With reload enabled, the counter re-arms itself and keeps running,
// which gives a periodic tick.
//
// Parameters
//   BW           width of the count, reload and load-value paths (2..32)
//
// Ports
//   clk_i        clock; all state changes on the rising edge
//   rst_i        asynchronous active-high reset
//   load_i       capture load_val_i as both the reload value and the count
//   load_val_i   terminal count to load (unsigned)
//   start_i      start from IDLE or resume from PAUSE
//   pause_i      pause while running
//   stop_i       abort to IDLE and keep the current count
//   reload_en_i  auto-reload enable, sampled on the expiry edge
//   count_o      current count register
//   busy_o       high in RUN or PAUSE
//   paused_o     high in PAUSE only
//   done_o       registered single-cycle expiry pulse
// -----------------------------------------------------------------------------
module countdown_timer #(
    parameter int BW = 8
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          load_i,
    input  logic [BW-1:0] load_val_i,
    input  logic          start_i,
    input  logic          pause_i,
    input  logic          stop_i,
    input  logic          reload_en_i,
    output logic [BW-1:0] count_o,
    output logic          busy_o,
    output logic          paused_o,
    output logic          done_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    localparam logic [BW-1:0] CNT_ZERO = '0;
    localparam logic [BW-1:0] CNT_ONE  = BW'(1);

    state_t        state_q,  state_d;
    logic [BW-1:0] count_q,  count_d;
    logic [BW-1:0] reload_q, reload_d;
    logic          done_q,   done_d;

    // Next-state logic. Priority on every edge: load, then stop, then the
    // per-state start/pause handling.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        done_d   = 1'b0;

        if (load_i) begin
            reload_d = load_val_i;
            count_d  = load_val_i;
            state_d  = ST_IDLE;
        end else if (stop_i) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        if (count_q != CNT_ZERO) begin
                            // The start edge only arms the counter; the first
                            // decrement happens on the following edge.
                            state_d = ST_RUN;
                        end else begin
                            // Nothing to count: report expiry immediately.
                            done_d = 1'b1;
                        end
                    end
                end

                ST_RUN: begin
                    if (pause_i) begin
                        // Pause wins over an expiry on the same edge.
                        state_d = ST_PAUSE;
                    end else if (count_q == CNT_ONE) begin
                        done_d = 1'b1;
                        if (reload_en_i && (reload_q != CNT_ZERO)) begin
                            count_d = reload_q;
                        end else begin
                            count_d = CNT_ZERO;
                            state_d = ST_IDLE;
                        end
                    end else if (count_q == CNT_ZERO) begin
                        // Unreachable in normal operation (RUN is only entered
                        // with a non-zero count); park safely without wrapping.
                        state_d = ST_IDLE;
                    end else begin
                        count_d = count_q - CNT_ONE;
                    end
                end

                ST_PAUSE: begin
                    // Resume without decrementing; pause_i has no effect here.
                    if (start_i) begin
                        state_d = ST_RUN;
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            reload_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            done_q   <= done_d;
        end
    end

    // Status flags are pure decodes of the state register.
    assign count_o  = count_q;
    assign busy_o   = (state_q == ST_RUN) || (state_q == ST_PAUSE);
    assign paused_o = (state_q == ST_PAUSE);
    assign done_o   = done_q;

endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 Parameter BW, default 8, SHALL set the width of the counter, reload and load-value paths; legal range 2..32.
REQ-002 clk_i  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst_i  input  1  SHALL be the reset: asynchronous, active-high.
REQ-004 load_i  input  1  SHALL be the load strobe: capture load_val_i as the new reload and count value.
REQ-005 load_val_i  input  BW  SHALL be the terminal count to load (unsigned).
REQ-006 start_i  input  1  SHALL be the start/resume request.
REQ-007 pause_i  input  1  SHALL be the pause request while running.
REQ-008 stop_i  input  1  SHALL be the abort request: return to IDLE, count held.
REQ-009 reload_en_i  input  1  SHALL be the auto-reload enable, sampled at expiry.
REQ-010 count_o  output  BW  SHALL present the current count register.
REQ-011 busy_o  output  1  SHALL be high in RUN or PAUSE.
REQ-012 paused_o  output  1  SHALL be high in PAUSE only.
REQ-013 done_o  output  1  SHALL be a registered single-cycle expiry pulse.

Function
REQ-014 States SHALL be IDLE, RUN and PAUSE; busy_o and paused_o SHALL be decoded from state only.
REQ-015 Per-edge priority SHALL be load_i > stop_i > start_i/pause_i.
REQ-016 load_i in any state SHALL set reload_val and count to load_val_i, force IDLE and clear done_o on that edge.
REQ-017 stop_i (no load_i) SHALL force IDLE with count and reload_val held; done_o low on that edge.
REQ-018 IDLE, start_i, count != 0: SHALL go to RUN; count SHALL NOT decrement on the start edge.
REQ-019 IDLE, start_i, count == 0: SHALL stay IDLE and pulse done_o for one cycle.
REQ-020 RUN, pause_i low: count SHALL decrement by 1 each edge.
REQ-021 RUN, pause_i high: SHALL go to PAUSE with count held on that edge; pause_i takes precedence over expiry on the same edge.
REQ-022 PAUSE: count SHALL hold; start_i SHALL return to RUN (no decrement on that edge); pause_i SHALL be ignored.
REQ-023 Expiry SHALL be a RUN edge with count == 1 and no pause/stop/load; done_o SHALL be 1 for exactly the following cycle.
REQ-024 At expiry with reload_en_i = 1 and reload_val != 0, count SHALL become reload_val and state SHALL stay RUN, giving a done_o period of reload_val cycles.
REQ-025 At expiry otherwise, count SHALL become 0 and state SHALL go to IDLE.
REQ-026 Latency: start on edge k with count N SHALL give done_o high in the cycle after edge k+N.
REQ-027 count SHALL never wrap below 0; arithmetic SHALL be BW-bit unsigned.
REQ-028 done_o SHALL be low on every edge other than those defined in REQ-019 and REQ-023.

Reset
REQ-029 While rst_i is high: count = 0, reload_val = 0, state = IDLE, done_o = 0, busy_o = 0, paused_o = 0, immediately and without a clock edge.
REQ-030 Reset asserted mid-RUN SHALL abort with no done_o pulse; after release the block SHALL need load_i before a non-zero run.
REQ-031 Reset deassertion SHALL take effect from the next rising clock edge.

Verification
REQ-032 Basic: load 3, start -> count 3,2,1,0 on successive edges; done_o high one cycle; busy_o low afterwards.
REQ-033 Reload: load 4, reload_en_i = 1, start -> done_o every 4 cycles; count cycles 4,3,2,1,4...; stop_i -> IDLE, count held.
REQ-034 Pause: load 5, start, pause after 2 decrements, hold 6 cycles, start -> count held at 3, then done_o 3 cycles after resume.
REQ-035 Corners: start with count 0 -> single done_o, stays IDLE; load_i and stop_i on the expiry edge -> no done_o, count = new load value (for load_i) or held value (for stop_i).
REQ-036 Reset: assert rst_i asynchronously mid-RUN with count 7 -> all outputs zero before the next clock edge, no done_o.
REQ-037 Width: BW = 4, load 15, reload on -> period 15, no underflow or wrap past 0.
